// File: rtl/rgb_breathe_pwm_pkg.sv
// Shared types and reset-phase helper for the RGB breathing PWM driver.
package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        SAW_UP   = 2'd1,
        TRIANGLE = 2'd2,
        SAW_DOWN = 2'd3
    } mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    // Channels start evenly spread across the duty range so they fade out of phase.
    function automatic int unsigned phase_init(input int unsigned i, input int unsigned ch,
                                               input int unsigned r);
        return i * ((32'd1 << r) / ch);
    endfunction

endpackage

// File: rtl/rgb_breathe_pwm_timebase.sv
// Shared PWM timebase: prescaler divides clk by dvsr+1, pwm_cnt advances on each tick.
module pwm_timebase #(
    parameter int R = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [31:0]   dvsr,
    output logic          tick,
    output logic [R-1:0]  pwm_cnt
);

    logic [31:0] prescaler;

    // dvsr is compared live, so a new divisor applies at the next compare.
    assign tick = en && (prescaler == dvsr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (!en) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (tick) begin
            prescaler <= '0;
            pwm_cnt   <= pwm_cnt + 1'b1;
        end else begin
            prescaler <= prescaler + 32'd1;
        end
    end

endmodule

// File: rtl/rgb_breathe_pwm.sv
// Multi-channel breathing PWM LED driver with sawtooth/triangle duty ramps.
// Define RGB_PWM_GAMMA_EN to apply a square-law gamma to the compared duty.
module rgb_breathe_pwm
    import rgb_pwm_pkg::*;
#(
    parameter int CH       = 3,
    parameter int R        = 8,
    parameter int STEP_DIV = 2_499_999
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [31:0]         dvsr,
    input  logic [CH-1:0]       ch_mask,
    output logic [CH-1:0]       pwm_out,
    output logic [CH*(R+1)-1:0] duty_mon,
    output logic                step_pulse
);

    localparam logic [R:0] DUTY_MAX = {1'b1, {R{1'b0}}};

    logic [R-1:0] pwm_cnt;
    logic         unused_tick;
    logic [31:0]  step_cnt;
    logic         step_now;
    mode_e        mode_cur;

    pwm_timebase #(.R(R)) u_timebase (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .dvsr    (dvsr),
        .tick    (unused_tick),
        .pwm_cnt (pwm_cnt)
    );

    assign step_now = en && (step_cnt == 32'(STEP_DIV));
    assign mode_cur = mode_e'(mode);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt   <= '0;
            step_pulse <= 1'b0;
        end else if (!en) begin
            step_cnt   <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= step_now;
            step_cnt   <= step_now ? 32'd0 : step_cnt + 32'd1;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [R:0] duty;
        logic [R:0] duty_eff;
        dir_e       dir;
        logic       pwm_q;

        // Duty moves on the same edge that raises step_pulse; mode is only looked at here.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                duty <= (R+1)'(phase_init(i, CH, R));
                dir  <= UP;
            end else if (step_now) begin
                case (mode_cur)
                    HOLD: ;
                    SAW_UP: begin
                        dir  <= UP;
                        duty <= (duty == DUTY_MAX) ? '0 : duty + 1'b1;
                    end
                    SAW_DOWN: begin
                        dir  <= UP;
                        duty <= (duty == '0) ? DUTY_MAX : duty - 1'b1;
                    end
                    TRIANGLE: begin
                        if (dir == UP) begin
                            if (duty == DUTY_MAX) begin
                                duty <= DUTY_MAX - 1'b1;
                                dir  <= DOWN;
                            end else begin
                                duty <= duty + 1'b1;
                                if (duty == DUTY_MAX - 1'b1) dir <= DOWN;
                            end
                        end else begin
                            if (duty == '0) begin
                                duty <= (R+1)'(1);
                                dir  <= UP;
                            end else begin
                                duty <= duty - 1'b1;
                                if (duty == (R+1)'(1)) dir <= UP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

`ifdef RGB_PWM_GAMMA_EN
        logic [2*R+1:0] duty_sq;
        assign duty_sq  = (2*R+2)'(duty) * (2*R+2)'(duty);
        assign duty_eff = (R+1)'(duty_sq >> R);
`else
        assign duty_eff = duty;
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) pwm_q <= 1'b0;
            else       pwm_q <= en & ch_mask[i] & ({1'b0, pwm_cnt} < duty_eff);
        end

        assign pwm_out[i]                = pwm_q;
        assign duty_mon[i*(R+1) +: R+1]  = duty;
    end

endmodule

// File: tb/tb_rgb_breathe_pwm.sv
// Self-checking bench for rgb_breathe_pwm (R=4, CH=3, STEP_DIV=3) with a duty scoreboard.
module tb_rgb_breathe_pwm;

    localparam int CH       = 3;
    localparam int R        = 4;
    localparam int STEP_DIV = 3;
    localparam int DW       = R + 1;
    localparam int W        = CH * DW;
    localparam int DMAX     = 1 << R;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [1:0]    mode;
    logic [31:0]   dvsr;
    logic [CH-1:0] ch_mask;
    logic [CH-1:0] pwm_out;
    logic [W-1:0]  duty_mon;
    logic          step_pulse;

    rgb_breathe_pwm #(.CH(CH), .R(R), .STEP_DIV(STEP_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .dvsr       (dvsr),
        .ch_mask    (ch_mask),
        .pwm_out    (pwm_out),
        .duty_mon   (duty_mon),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int n_steps  = 0;
    int n_pushed = 0;
    int cyc      = 0;
    int last_step = 0;
    bit last_valid = 1'b0;
    int m_duty[CH];
    int m_dir[CH];
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_vec();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) v[i*DW +: DW] = DW'(m_duty[i]);
        return v;
    endfunction

    function automatic int eff(input int d);
`ifdef RGB_PWM_GAMMA_EN
        return (d * d) >> R;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = i * (DMAX / CH);
            m_dir[i]  = 0;
        end
    endtask

    // md: 0 HOLD, 1 SAW_UP, 2 TRIANGLE, 3 SAW_DOWN; dir 0 = up, 1 = down
    task automatic push_steps(input int n, input int md);
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < CH; i++) begin
                case (md)
                    1: begin
                        m_dir[i]  = 0;
                        m_duty[i] = (m_duty[i] == DMAX) ? 0 : m_duty[i] + 1;
                    end
                    3: begin
                        m_dir[i]  = 0;
                        m_duty[i] = (m_duty[i] == 0) ? DMAX : m_duty[i] - 1;
                    end
                    2: begin
                        if (m_dir[i] == 0) begin
                            if (m_duty[i] == DMAX) begin
                                m_duty[i] = DMAX - 1;
                                m_dir[i]  = 1;
                            end else begin
                                m_duty[i]++;
                                if (m_duty[i] == DMAX) m_dir[i] = 1;
                            end
                        end else begin
                            if (m_duty[i] == 0) begin
                                m_duty[i] = 1;
                                m_dir[i]  = 0;
                            end else begin
                                m_duty[i]--;
                                if (m_duty[i] == 0) m_dir[i] = 0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            exp_q.push_back(model_vec());
            n_pushed++;
        end
    endtask

    task automatic wait_all(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            check("wait_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        cyc++;
        if (reset || !en) last_valid = 1'b0;
        if (step_pulse) begin
            n_steps++;
            if (last_valid) check("step_spacing", cyc - last_step, STEP_DIV + 1);
            last_step  = cyc;
            last_valid = 1'b1;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_step", n_steps, n_pushed);
            end else begin
                e = exp_q.pop_front();
                check("duty_mon", duty_mon, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi0, hi1, hi2, tog1, bad_pwm, bad_step, bad_duty, k;
        logic prev1;
        logic [W-1:0] snap;

        reset = 1'b1; en = 1'b0; mode = 2'd0; dvsr = 32'd0; ch_mask = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_duty", duty_mon, model_vec());
        check("rst_pwm", pwm_out, 0);
        check("rst_step", step_pulse, 0);

        // SAW_UP: ch0 climbs 1..16
        reset = 1'b0; en = 1'b1; ch_mask = 3'b111; mode = 2'd1;
        push_steps(16, 1);
        wait_all(200);
        check("ch0_at_max", duty_mon[DW-1:0], DMAX);

        // freeze at 16 and confirm a full PWM period of constant high
        push_steps(4, 0);
        mode = 2'd0;
        hi0 = 0;
        repeat (16) begin
            @(negedge clk);
            hi0 += int'(pwm_out[0]);
        end
        check("ch0_full_high", hi0, 16);
        @(posedge clk);
        #1;
        wait_all(50);
        push_steps(2, 1);
        mode = 2'd1;
        wait_all(50);

        // reset asserted while step_pulse is high
        k = 0;
        while (!step_pulse && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("pre_reset_pulse", step_pulse, 1);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("midrst_duty", duty_mon, model_vec());
        check("midrst_pwm", pwm_out, 0);
        check("midrst_step", step_pulse, 0);
        mode = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // TRIANGLE: ch2 goes 11..16, 15..0, 1
        push_steps(23, 2);
        wait_all(200);
        check("ch2_tri_end", duty_mon[2*DW +: DW], 1);
        push_steps(3, 0);
        mode = 2'd0;
        wait_all(60);

        // PWM duty with dvsr=2, HOLD
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        dvsr = 32'd2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_steps(14, 0);
        repeat (2) @(negedge clk);
        hi0 = 0; hi1 = 0; hi2 = 0;
        repeat (48) begin
            @(negedge clk);
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
            hi2 += int'(pwm_out[2]);
        end
        check("pwm_ch0_high", hi0, eff(m_duty[0]) * 3);
        check("pwm_ch1_high", hi1, eff(m_duty[1]) * 3);
        check("pwm_ch2_high", hi2, eff(m_duty[2]) * 3);
        wait_all(100);

        // gating: only ch1 enabled, all channels keep ramping
        en = 1'b0;
        dvsr = 32'd0;
        @(posedge clk);
        #1;
        en = 1'b1; ch_mask = 3'b010; mode = 2'd1;
        push_steps(12, 1);
        hi0 = 0; hi2 = 0; tog1 = 0; prev1 = pwm_out[1];
        repeat (40) begin
            @(negedge clk);
            hi0 += int'(pwm_out[0]);
            hi2 += int'(pwm_out[2]);
            if (pwm_out[1] != prev1) tog1++;
            prev1 = pwm_out[1];
        end
        check("mask_ch0_low", hi0, 0);
        check("mask_ch2_low", hi2, 0);
        check("mask_ch1_toggles", tog1 > 4, 1);
        wait_all(100);

        // en low for 20 cycles
        en = 1'b0;
        snap = model_vec();
        @(posedge clk);
        bad_pwm = 0; bad_step = 0; bad_duty = 0;
        repeat (20) begin
            @(negedge clk);
            if (pwm_out != '0) bad_pwm++;
            if (step_pulse) bad_step++;
            if (duty_mon !== snap) bad_duty++;
        end
        check("en_off_pwm", bad_pwm, 0);
        check("en_off_step", bad_step, 0);
        check("en_off_duty", bad_duty, 0);
        @(posedge clk);
        #1;
        push_steps(1, 1);
        en = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!step_pulse && k < 20);
        check("en_first_step", k, STEP_DIV + 1);
        wait_all(20);

        check("sb_leftover", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
